// File: rtl/pg_pkg.sv
// Shared constants and types for the pg step sequencer.
// A step is a pattern byte plus a repeat count; the step plays for rpt+1 cycles.
package pg_pkg;

    localparam int PG_PW    = 8;
    localparam int PG_RW    = 4;
    localparam int PG_DEPTH = 16;

    typedef struct packed {
        logic [PG_RW-1:0] rpt;
        logic [PG_PW-1:0] pat;
    } pg_step_t;

    typedef enum logic {
        PG_IDLE = 1'b0,
        PG_RUN  = 1'b1
    } pg_state_e;

endpackage

// File: rtl/pg_step_mem.sv
// Step register file: one synchronous write port and one combinational read port.
// The contents are not reset; the sequencer's pointers decide which entries are valid.
import pg_pkg::*;

module pg_step_mem #(
    parameter int DEPTH = PG_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  pg_step_t       wdata,
    input  logic [AW-1:0]  raddr,
    output pg_step_t       rdata
);

    pg_step_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pg_step_sequencer.sv
// Programmable step sequencer: steps are loaded as byte pairs (pattern, repeat)
// while idle and then played back on a registered pattern bus.
import pg_pkg::*;

module pg_step_sequencer #(
    parameter int DEPTH = PG_DEPTH,
    parameter int PW    = PG_PW,
    parameter int RW    = PG_RW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    input  logic          clear,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    output logic [PW-1:0] pat_out,
    output logic          pat_valid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_idx,
    output logic [AW:0]   length
);

    pg_state_e     state;
    logic [AW:0]   wr_ptr;
    logic          phase;
    logic [PW-1:0] pat_latch;
    logic [AW-1:0] rd_idx;
    logic [RW-1:0] rpt_cnt;

    logic [AW:0]   last_ptr;
    logic          at_last;
    logic          start_go;
    logic          xfer;
    logic          mem_we;
    logic [AW-1:0] rd_addr;
    pg_step_t      wr_step;
    pg_step_t      rd_step;

    assign last_ptr   = wr_ptr - (AW+1)'(1);
    assign at_last    = (rd_idx == last_ptr[AW-1:0]);
    assign start_go   = (state == PG_IDLE) & start & ~stop & (wr_ptr != '0);
    // wr_ptr[AW] is set exactly when the program is full (DEPTH is a power of two)
    assign load_ready = ena & (state == PG_IDLE) & ~wr_ptr[AW] & ~clear;
    assign xfer       = load_valid & load_ready;
    assign mem_we     = xfer & phase & ~start_go;

    // The read port always presents the entry the next edge may need to load.
    assign rd_addr = ((state == PG_RUN) && !at_last) ? rd_idx + AW'(1) : '0;

    assign wr_step.rpt = load_data[RW-1:0];
    assign wr_step.pat = pat_latch;

    assign length   = wr_ptr;
    assign step_idx = rd_idx;

    pg_step_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_step),
        .raddr (rd_addr),
        .rdata (rd_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PG_IDLE;
            wr_ptr    <= '0;
            phase     <= 1'b0;
            pat_latch <= '0;
            rd_idx    <= '0;
            rpt_cnt   <= '0;
            pat_out   <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                PG_IDLE: begin
                    if (clear) begin
                        wr_ptr <= '0;
                        phase  <= 1'b0;
                    end else if (start_go) begin
                        state     <= PG_RUN;
                        rd_idx    <= '0;
                        rpt_cnt   <= rd_step.rpt;
                        pat_out   <= rd_step.pat;
                        pat_valid <= 1'b1;
                        busy      <= 1'b1;
                        phase     <= 1'b0;
                    end else if (xfer) begin
                        if (!phase) begin
                            pat_latch <= load_data[PW-1:0];
                            phase     <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + (AW+1)'(1);
                            phase  <= 1'b0;
                        end
                    end
                end
                PG_RUN: begin
                    if (stop) begin
                        state     <= PG_IDLE;
                        pat_out   <= '0;
                        pat_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (rpt_cnt != '0) begin
                        rpt_cnt <= rpt_cnt - RW'(1);
                    end else if (!at_last || loop_en) begin
                        rd_idx  <= rd_addr;
                        rpt_cnt <= rd_step.rpt;
                        pat_out <= rd_step.pat;
                    end else begin
                        state     <= PG_IDLE;
                        done      <= 1'b1;
                        pat_out   <= '0;
                        pat_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= PG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pg_step_sequencer.sv
// Self-checking bench for pg_step_sequencer: a step-expansion model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pg_step_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] pat_out;
    logic       pat_valid;
    logic       busy;
    logic       done;
    logic [3:0] step_idx;
    logic [4:0] length;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    pg_step_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .pat_out    (pat_out),
        .pat_valid  (pat_valid),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx),
        .length     (length)
    );

    always #5 clk = ~clk;

    // Model: the program is expanded into one entry per played cycle.
    int prog_pat [16];
    int prog_rpt [16];
    int m_cnt   = 0;
    int m_phase = 0;
    int m_latch = 0;
    bit m_run   = 1'b0;
    bit m_done  = 1'b0;
    int m_idx   = 0;
    int pos     = 0;
    int seq_pat [$];
    int seq_idx [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_phase = 0; m_latch = 0;
            m_run = 1'b0; m_done = 1'b0; m_idx = 0; pos = 0;
        end else if (ena) begin
            m_done = 1'b0;
            if (!m_run) begin
                if (clear) begin
                    m_cnt = 0; m_phase = 0;
                end else if (start && !stop && m_cnt != 0) begin
                    seq_pat.delete();
                    seq_idx.delete();
                    for (int s = 0; s < m_cnt; s++) begin
                        for (int r = 0; r <= prog_rpt[s]; r++) begin
                            seq_pat.push_back(prog_pat[s]);
                            seq_idx.push_back(s);
                        end
                    end
                    pos = 0; m_run = 1'b1; m_phase = 0;
                    m_idx = seq_idx[0];
                end else if (load_valid && m_cnt < 16) begin
                    if (m_phase == 0) begin
                        m_latch = load_data; m_phase = 1;
                    end else begin
                        prog_pat[m_cnt] = m_latch;
                        prog_rpt[m_cnt] = load_data[3:0];
                        m_cnt++; m_phase = 0;
                    end
                end
            end else begin
                if (stop) begin
                    m_run = 1'b0;
                end else begin
                    pos++;
                    if (pos == seq_pat.size()) begin
                        if (loop_en) pos = 0;
                        else begin m_run = 1'b0; m_done = 1'b1; end
                    end
                    if (m_run) m_idx = seq_idx[pos];
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            check_output("model pat_out",    pat_out,    m_run ? seq_pat[pos] : 0);
            check_output("model pat_valid",  pat_valid,  m_run);
            check_output("model busy",       busy,       m_run);
            check_output("model done",       done,       m_done);
            check_output("model step_idx",   step_idx,   m_idx);
            check_output("model length",     length,     m_cnt);
            check_output("model load_ready", load_ready,
                         (ena && !m_run && m_cnt < 16 && !clear) ? 1 : 0);
        end
    end

    task automatic load_step(input logic [7:0] p, input logic [3:0] r);
        @(negedge clk); load_valid = 1'b1; load_data = p;
        @(negedge clk); load_data = {4'h0, r};
        @(negedge clk); load_valid = 1'b0;
    endtask

    task automatic load_demo();
        load_step(8'hA5, 4'd0);
        load_step(8'h3C, 4'd2);
        load_step(8'hFF, 4'd1);
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk); #2;
    endtask

    initial begin
        int exp_pat [6];
        int exp_idx [6];
        exp_pat = '{8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 8'hFF};
        exp_idx = '{0, 1, 1, 1, 2, 2};

        // Reset
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("reset pat_out", pat_out, 0);
        check_output("reset length", length, 0);
        check_output("reset load_ready", load_ready, 1);

        // 1: single run
        load_demo();
        check_output("t1 length", length, 3);
        @(negedge clk); start = 1'b1;
        after_edge();
        check_output("t1 pat[0]", pat_out, exp_pat[0]);
        check_output("t1 idx[0]", step_idx, exp_idx[0]);
        @(negedge clk); start = 1'b0;
        for (int i = 1; i < 6; i++) begin
            after_edge();
            check_output("t1 pat", pat_out, exp_pat[i]);
            check_output("t1 idx", step_idx, exp_idx[i]);
        end
        after_edge();
        check_output("t1 done", done, 1);
        check_output("t1 pat_valid", pat_valid, 0);
        after_edge();
        check_output("t1 done clears", done, 0);

        // 2: looping run
        @(negedge clk); loop_en = 1'b1; start = 1'b1;
        after_edge();
        @(negedge clk); start = 1'b0;
        for (int i = 1; i < 12; i++) begin
            after_edge();
            check_output("t2 pat", pat_out, exp_pat[i % 6]);
            check_output("t2 busy", busy, 1);
            check_output("t2 done", done, 0);
        end
        @(negedge clk); stop = 1'b1; loop_en = 1'b0;
        @(negedge clk); stop = 1'b0;

        // 3: fill to capacity, then offer one more byte
        do_clear();
        for (int i = 0; i < 16; i++) load_step(8'(i * 17 + 1), 4'(i % 4));
        @(negedge clk); load_valid = 1'b1; load_data = 8'h77;
        repeat (3) after_edge();
        check_output("t3 full length", length, 16);
        check_output("t3 full load_ready", load_ready, 0);
        @(negedge clk); load_valid = 1'b0;
        do_clear();
        #1;
        check_output("t3 cleared length", length, 0);
        check_output("t3 cleared load_ready", load_ready, 1);

        // 4: start ignored when empty, stop beats start
        @(negedge clk); start = 1'b1;
        repeat (3) after_edge();
        check_output("t4 empty start busy", busy, 0);
        @(negedge clk); start = 1'b0;
        load_demo();
        @(negedge clk); start = 1'b1; stop = 1'b1;
        repeat (2) after_edge();
        check_output("t4 start+stop busy", busy, 0);
        @(negedge clk); start = 1'b0; stop = 1'b0;

        // 5: stop mid-run, then restart
        @(negedge clk); start = 1'b1;
        after_edge();
        @(negedge clk); start = 1'b0;
        repeat (2) after_edge();
        check_output("t5 pre-stop idx", step_idx, 1);
        check_output("t5 pre-stop pat", pat_out, 8'h3C);
        @(negedge clk); stop = 1'b1;
        after_edge();
        check_output("t5 stop pat", pat_out, 0);
        check_output("t5 stop busy", busy, 0);
        check_output("t5 stop done", done, 0);
        @(negedge clk); stop = 1'b0; start = 1'b1;
        after_edge();
        check_output("t5 restart pat", pat_out, 8'hA5);
        check_output("t5 restart idx", step_idx, 0);

        // 6: asynchronous reset mid-run, then enable gating
        @(negedge clk); start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_output("t6 async pat_out", pat_out, 0);
        check_output("t6 async pat_valid", pat_valid, 0);
        check_output("t6 async busy", busy, 0);
        check_output("t6 async length", length, 0);
        @(negedge clk); rst_n = 1'b1;
        load_demo();
        @(negedge clk); start = 1'b1;
        after_edge();
        @(negedge clk); start = 1'b0;
        after_edge();
        check_output("t6 pre-hold pat", pat_out, 8'h3C);
        @(negedge clk); ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            after_edge();
            check_output("t6 hold pat", pat_out, 8'h3C);
            check_output("t6 hold idx", step_idx, 1);
            check_output("t6 hold load_ready", load_ready, 0);
        end
        @(negedge clk); ena = 1'b1;
        repeat (3) after_edge();
        check_output("t6 resume pat", pat_out, 8'hFF);
        check_output("t6 resume idx", step_idx, 2);
        repeat (4) @(negedge clk);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pg_step_sequencer.md
Name: pg_step_sequencer

Overview:
Programmable step sequencer that drives the pattern datapath of tt_um_htfab_pg_1x1. It holds up to DEPTH steps, each an 8-bit pattern plus a 4-bit repeat count. Steps are loaded over a byte-wide valid/ready channel fed from ui_in/uio_in. After start, the steps are played out on a registered pattern bus that the top level routes to uo_out.

Parameters:
DEPTH, 16, number of step entries (power of two, ≥2)
PW, 8, pattern width
RW, 4, repeat-count width; a step is held for rpt+1 cycles

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous and active-low
ena  input  1  tile enable; when low, all state holds
load_valid  input  1  load byte present
load_data  input  8  load byte
load_ready  output  1  sequencer accepts a load byte this cycle
clear  input  1  empties program (wr_ptr←0, byte phase←0)
start  input  1  begin playback (level, sampled)
stop  input  1  abort playback
loop_en  input  1  wrap to step 0 after the last step instead of finishing
pat_out  output  PW  current pattern (registered)
pat_valid  output  1  pat_out is live
busy  output  1  in RUN
done  output  1  one-cycle pulse when a non-looping run completes
step_idx  output  log2(DEPTH)  index of the step being played
length  output  log2(DEPTH)+1  number of loaded steps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wr_ptr=0, phase=0, rd_idx=0, rpt_cnt=0.
  - All outputs are 0; load_ready becomes 1 after reset if ena=1.
- ena=0: no register updates. load_ready=0. Outputs hold their last values.
- States are IDLE and RUN. Memory is DEPTH×(RW+PW) flops, no reset needed; only the pointers reset.
- IDLE:
  - load_ready = ena & (wr_ptr<DEPTH) & ~clear.
  - A transfer occurs when load_valid&load_ready.
  - phase 0: latch load_data as the pattern byte, then phase←1.
  - phase 1: write {load_data[RW-1:0], latched pattern} to mem[wr_ptr], then wr_ptr++ and phase←0. load_data[7:RW] are ignored.
  - length = wr_ptr. Full when wr_ptr==DEPTH: load_ready=0 and bytes are not consumed.
  - clear has priority over a load in the same cycle.
- IDLE→RUN when start=1, stop=0 and length≠0.
  - On that edge: rd_idx←0, rpt_cnt←mem[0].rpt, pat_out←mem[0].pat, pat_valid←1, busy←1.
  - Latency: start sampled at edge N gives the step-0 pattern visible after edge N.
  - start with length==0 is ignored.
  - If start arrives while phase=1, the half-loaded byte is discarded (phase←0).
- RUN, each enabled cycle:
  - If stop: go to IDLE. pat_out←0, pat_valid←0, busy←0, no done pulse.
  - Else if rpt_cnt≠0: rpt_cnt--.
  - Else if rd_idx≠length-1: rd_idx++ and load the next entry's pat and rpt.
  - Else if loop_en: rd_idx←0 and reload entry 0. There are no gap cycles between steps.
  - Else: go to IDLE, done←1 for one cycle, pat_out←0, pat_valid←0, busy←0.
  - load_ready=0 and clear is ignored during RUN.
- start and stop in the same cycle: stop wins, so the state stays in or goes to IDLE.
- loop_en is sampled only at the last-step decision.
- Total cycles of a non-looping run: Σ(rpt_i+1). done asserts on the edge after the last pattern cycle.
- step_idx = rd_idx.

Decomposition:
- Package pg_pkg holds:
  - PG_PW, PG_RW, PG_DEPTH constants.
  - typedef pg_step_t = struct {rpt, pat}.
  - enum pg_state_e {PG_IDLE, PG_RUN}.
- One sub-module, pg_step_mem: DEPTH×pg_step_t register file with one write port and one combinational read port.
- The FSM, pointers and load logic stay in pg_step_sequencer.

Test Plan:
1. Reset, then load 3 steps (A5/r0, 3C/r2, FF/r1) and start with loop_en=0:
   - pat_out = A5,3C,3C,3C,FF,FF.
   - step_idx = 0,1,1,1,2,2.
   - done pulses on the next cycle, then pat_valid=0.
2. Same program with loop_en=1 for 12 cycles:
   - The sequence repeats with period 6 and no gap.
   - busy stays 1 and done never pulses.
3. Load 16 steps, then offer a 17th:
   - load_ready=0, length=16, and the extra byte is not consumed.
   - clear, then length=0 and load_ready=1.
4. Start with length=0:
   - busy stays 0.
   - start and stop asserted together with length=3: no RUN.
5. stop mid-run at step 1 (rpt_cnt=1):
   - The next cycle gives pat_out=00, busy=0, done=0.
   - A restart replays from step 0.
6. Drop rst_n asynchronously mid-run:
   - Outputs go to 0 immediately, without waiting for a clock edge, and length=0.
   - Then ena=0 during RUN: pat_out and step_idx hold for the 5 disabled cycles and resume when ena returns to 1.
